// File: rtl/arb_pkg.sv
// Shared types for the round-robin stream arbiter.
//   arb_state_e : IDLE arbitrates every cycle, LOCKED holds the grant
//                 for the remaining beats of a multi-beat packet.
package arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotated priority encoder: finds the first set bit of valid, scanning
// base, base+1, ... wrapping modulo N.
//   valid [N]         : candidate requests
//   base  [IDX_WIDTH] : scan start index (0..N-1)
//   idx   [IDX_WIDTH] : winning index (0 when nothing is valid)
//   any               : at least one candidate is valid
module rr_pick #(
    parameter int N         = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [N-1:0]         valid,
    input  logic [IDX_WIDTH-1:0] base,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 any
);

    localparam int unsigned NU = N;

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;
    logic           found;

    // The request vector is doubled so the wrap-around becomes a plain
    // linear scan over the window [base, base+N).
    always_comb begin
        dbl    = {valid, valid};
        masked = '0;
        idx    = '0;
        found  = 1'b0;
        any    = |valid;
        for (int unsigned j = 0; j < 2 * NU; j++) begin
            masked[j] = dbl[j] & (j >= 32'(base)) & (j < 32'(base) + NU);
        end
        for (int unsigned j = 0; j < 2 * NU; j++) begin
            if (masked[j] && !found) begin
                found = 1'b1;
                idx   = (j >= NU) ? IDX_WIDTH'(j - NU) : IDX_WIDTH'(j);
            end
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream among N requesters.
// A grant is held for the whole of a multi-beat packet and released on the
// beat carrying last; the priority pointer then moves just past the owner.
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid[N] : per-requester beat valid
//   req_last[N]  : per-requester last beat (meaningful with valid only)
//   req_ready[N] : per-requester accept, at most one bit set
//   out_valid    : shared stream valid
//   out_last     : shared stream last
//   out_ready    : downstream accept
//   grant_idx    : current winner/owner, payload mux select for the parent
//   grant_onehot : one-hot grant_idx, gated by out_valid
//   busy         : a multi-beat packet holds the lock
module rr_stream_arbiter
    import arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int IDX_WIDTH = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_ready,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic [N-1:0]         grant_onehot,
    output logic                 busy
);

    localparam int unsigned NU = N;

    arb_state_e             state, state_next;
    logic [IDX_WIDTH-1:0]   ptr, ptr_next;
    logic [IDX_WIDTH-1:0]   owner, owner_next;
    logic [IDX_WIDTH-1:0]   pick_idx;
    logic                   pick_any;
    logic [IDX_WIDTH-1:0]   sel;
    logic                   hs;

    // Explicit compare against N-1 so non-power-of-two N wraps correctly.
    function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] x);
        return (32'(x) == NU - 1) ? '0 : x + IDX_WIDTH'(1);
    endfunction

    rr_pick #(
        .N         (N),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .valid (req_valid),
        .base  (ptr),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        if (state == ARB_LOCKED) begin
            sel = owner;
        end else if (pick_any) begin
            sel = pick_idx;
        end else begin
            sel = ptr;
        end

        out_valid    = 1'b0;
        out_last     = 1'b0;
        req_ready    = '0;
        grant_onehot = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (32'(sel) == i) begin
                out_valid       = req_valid[i];
                out_last        = req_last[i] & req_valid[i];
                req_ready[i]    = req_valid[i] & out_ready;
                grant_onehot[i] = req_valid[i];
            end
        end
        grant_idx = sel;
        busy      = (state == ARB_LOCKED);
        hs        = out_valid & out_ready;

        state_next = state;
        ptr_next   = ptr;
        owner_next = owner;
        case (state)
            ARB_IDLE: begin
                if (hs) begin
                    if (out_last) begin
                        ptr_next = wrap_inc(sel);
                    end else begin
                        state_next = ARB_LOCKED;
                        owner_next = sel;
                    end
                end
            end
            ARB_LOCKED: begin
                if (hs && out_last) begin
                    state_next = ARB_IDLE;
                    ptr_next   = wrap_inc(owner);
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // With a single requester the pointer and owner are always 0, so no
    // registers are built for them.
    generate
        if (N > 1) begin : g_ptr
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ptr   <= '0;
                    owner <= '0;
                end else begin
                    ptr   <= ptr_next;
                    owner <= owner_next;
                end
            end
        end else begin : g_noptr
            assign ptr   = '0;
            assign owner = '0;
        end
    endgenerate

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter: a vector table for N=4 plus
// hand-written sequences for backpressure, reset mid-packet, N=3 wrap and
// the N=1 degenerate case.
module tb_rr_stream_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // N=4 instance
    logic [3:0] v4, l4, rdy4, oh4;
    logic       ordy4, ov4, ol4, busy4;
    logic [1:0] idx4;

    rr_stream_arbiter #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_last(l4), .req_ready(rdy4),
        .out_valid(ov4), .out_last(ol4), .out_ready(ordy4), .grant_idx(idx4),
        .grant_onehot(oh4), .busy(busy4)
    );

    // N=3 instance
    logic [2:0] v3, l3, rdy3, oh3;
    logic       ordy3, ov3, ol3, busy3;
    logic [1:0] idx3;

    rr_stream_arbiter #(.N(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_last(l3), .req_ready(rdy3),
        .out_valid(ov3), .out_last(ol3), .out_ready(ordy3), .grant_idx(idx3),
        .grant_onehot(oh3), .busy(busy3)
    );

    // N=1 instance
    logic [0:0] v1, l1, rdy1, oh1;
    logic       ordy1, ov1, ol1, busy1;
    logic [0:0] idx1;

    rr_stream_arbiter #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_last(l1), .req_ready(rdy1),
        .out_valid(ov1), .out_last(ol1), .out_ready(ordy1), .grant_idx(idx1),
        .grant_onehot(oh1), .busy(busy1)
    );

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       ready;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic       exp_ol;
        logic [1:0] exp_idx;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] erdy, input logic eov,
                        input logic eol, input logic [1:0] eidx, input logic ebusy);
        chk({name, ".req_ready"}, 32'(rdy4), 32'(erdy));
        chk({name, ".out_valid"}, 32'(ov4), 32'(eov));
        chk({name, ".out_last"}, 32'(ol4), 32'(eol));
        chk({name, ".grant_idx"}, 32'(idx4), 32'(eidx));
        chk({name, ".grant_onehot"}, 32'(oh4), eov ? (32'd1 << eidx) : 32'd0);
        chk({name, ".busy"}, 32'(busy4), 32'(ebusy));
    endtask

    // Inputs change 1 time unit after a rising edge, outputs are checked
    // one unit later, then the next rising edge commits the cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        v4 = '0; l4 = '0; ordy4 = 1'b1;
        v3 = '0; l3 = '0; ordy3 = 1'b1;
        v1 = '0; l1 = '0; ordy1 = 1'b1;

        //            valid    last     rdy   exp_rdy  ov    ol    idx    busy
        vecs[0]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0};
        vecs[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0};
        vecs[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0};
        vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0};
        vecs[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0};
        // req1 3-beat packet with req2 valid throughout
        vecs[6]  = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd1, 1'b0};
        vecs[7]  = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd1, 1'b1};
        vecs[8]  = '{4'b0110, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1};
        vecs[9]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0};
        vecs[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0};
        // owner 0 locks, then drops valid for 2 cycles while req3 waits
        vecs[11] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[12] = '{4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[13] = '{4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[14] = '{4'b1001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1};
        // ptr=1 now; no handshake, selection follows valids, ptr holds
        vecs[15] = '{4'b1001, 4'b1001, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0};
        vecs[16] = '{4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0};
        vecs[17] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0};

        // Reset state
        #2;
        chk4("reset", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        for (int i = 0; i < 18; i++) begin
            v4 = vecs[i].valid; l4 = vecs[i].last; ordy4 = vecs[i].ready;
            #1;
            chk4($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_ov,
                 vecs[i].exp_ol, vecs[i].exp_idx, vecs[i].exp_busy);
            next_cycle();
        end

        // Backpressure inside a locked packet: ptr=1, req1 locks first.
        v4 = 4'b0010; l4 = 4'b0000; ordy4 = 1'b1;
        #1;
        chk4("bp_start", 4'b0010, 1'b1, 1'b0, 2'd1, 1'b0);
        next_cycle();
        v4 = 4'b0110; ordy4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk4($sformatf("bp%0d", i), 4'b0000, 1'b1, 1'b0, 2'd1, 1'b1);
            next_cycle();
        end

        // Asynchronous reset mid-packet, away from any clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async.busy", 32'(busy4), 32'd0);
        v4 = 4'b0000;
        #1;
        chk4("rst_hold", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        v4 = 4'b1111; l4 = 4'b1111; ordy4 = 1'b1;
        #1;
        chk4("post_rst0", 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
        next_cycle();
        #1;
        chk4("post_rst1", 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);
        next_cycle();
        v4 = '0; l4 = '0;

        // N=3: move ptr to 2 with a req1 single beat, then wrap.
        v3 = 3'b010; l3 = 3'b010;
        #1;
        chk("n3_a.idx", 32'(idx3), 32'd1);
        next_cycle();
        v3 = 3'b101; l3 = 3'b101;
        #1;
        chk("n3_b.idx", 32'(idx3), 32'd2);
        chk("n3_b.rdy", 32'(rdy3), 32'b100);
        next_cycle();
        #1;
        chk("n3_c.idx", 32'(idx3), 32'd0);
        chk("n3_c.rdy", 32'(rdy3), 32'b001);
        next_cycle();
        v3 = 3'b000;
        #1;
        chk("n3_d.idx", 32'(idx3), 32'd1);
        next_cycle();

        // N=1: 3-beat packet with a stalled last beat.
        v1 = 1'b1; l1 = 1'b0; ordy1 = 1'b1;
        #1;
        chk("n1_a.rdy", 32'(rdy1), 32'd1);
        chk("n1_a.busy", 32'(busy1), 32'd0);
        next_cycle();
        #1;
        chk("n1_b.busy", 32'(busy1), 32'd1);
        next_cycle();
        l1 = 1'b1; ordy1 = 1'b0;
        #1;
        chk("n1_c.rdy", 32'(rdy1), 32'd0);
        chk("n1_c.ov", 32'(ov1), 32'd1);
        chk("n1_c.busy", 32'(busy1), 32'd1);
        next_cycle();
        ordy1 = 1'b1;
        #1;
        chk("n1_d.rdy", 32'(rdy1), 32'd1);
        chk("n1_d.ol", 32'(ol1), 32'd1);
        chk("n1_d.idx", 32'(idx1), 32'd0);
        next_cycle();
        v1 = 1'b0;
        #1;
        chk("n1_e.busy", 32'(busy1), 32'd0);
        chk("n1_e.rdy", 32'(rdy1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
